// File: rtl/eth_hdr_parse.sv
// eth_hdr_parse: reads a 14-byte Ethernet header from the RX buffer and extracts MACs, EtherType and flags
module eth_hdr_parse #(
   parameter logic ACCEPT_BCAST = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [7:0]  i_mac0,
   input  logic [7:0]  i_mac1,
   input  logic [7:0]  i_mac2,
   input  logic [7:0]  i_mac3,
   input  logic [7:0]  i_mac4,
   input  logic [7:0]  i_mac5,
   input  logic        i_start,
   output logic [3:0]  o_rd_addr,
   output logic        o_rd_en,
   input  logic [7:0]  i_rd_data,
   output logic [47:0] o_dst_mac,
   output logic [47:0] o_src_mac,
   output logic [15:0] o_ethertype,
   output logic        o_is_bcast,
   output logic        o_match,
   output logic        o_is_ip,
   output logic        o_busy,
   output logic        o_done
);
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_CHECK = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]   r_state;
   logic         r_start_d;
   logic [3:0]   r_rd_cnt;
   logic         r_cap_vld;
   logic [3:0]   r_cap_off;
   logic [111:0] r_hdr;
   logic [47:0]  r_dst_mac;
   logic [47:0]  r_src_mac;
   logic [15:0]  r_ethertype;
   logic         r_is_bcast;
   logic         r_match;
   logic         r_is_ip;

   logic         w_trig;
   logic [47:0]  w_dst;
   logic [47:0]  w_src;
   logic [15:0]  w_type;
   logic [47:0]  w_local;
   logic         w_bcast;
   logic         w_match;
   logic         w_ip;

   assign w_trig      = (r_state == S_IDLE) & i_start & ~r_start_d;
   assign w_dst       = r_hdr[111:64];
   assign w_src       = r_hdr[63:16];
   assign w_type      = r_hdr[15:0];
   assign w_local     = {i_mac0, i_mac1, i_mac2, i_mac3, i_mac4, i_mac5};
   assign w_bcast     = (w_dst == 48'hFFFF_FFFF_FFFF);
   assign w_match     = (w_dst == w_local) | (w_bcast & ACCEPT_BCAST);
   assign w_ip        = (w_type == 16'h0800);

   assign o_rd_en     = (r_state == S_READ);
   assign o_rd_addr   = r_rd_cnt;
   assign o_busy      = (r_state == S_READ) | (r_state == S_DRAIN) | (r_state == S_CHECK) | (r_state == S_DONE);
   assign o_done      = (r_state == S_DONE);
   assign o_dst_mac   = r_dst_mac;
   assign o_src_mac   = r_src_mac;
   assign o_ethertype = r_ethertype;
   assign o_is_bcast  = r_is_bcast;
   assign o_match     = r_match;
   assign o_is_ip     = r_is_ip;

   // Delayed start level for rising-edge detection, tracked in every state
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_start_d <= 1'b0;
      else       r_start_d <= i_start;
   end

   // Parse sequencer; the read counter keeps its last address outside READ
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_rd_cnt <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_trig) begin
                  r_state  <= S_READ;
                  r_rd_cnt <= 4'd0;
               end
            end
            S_READ: begin
               if (r_rd_cnt == 4'd13) r_state  <= S_DRAIN;
               else                   r_rd_cnt <= r_rd_cnt + 4'd1;
            end
            S_DRAIN: r_state <= S_CHECK;
            S_CHECK: r_state <= S_DONE;
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Buffer data trails the address by one cycle, so remember which byte is in flight
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cap_vld <= 1'b0;
         r_cap_off <= 4'd0;
         r_hdr     <= '0;
      end else begin
         r_cap_vld <= (r_state == S_READ);
         r_cap_off <= 4'd13 - r_rd_cnt;
         if (r_cap_vld) r_hdr[{r_cap_off, 3'b000} +: 8] <= i_rd_data;
      end
   end

   // Results change only on entry to DONE, so a partial header is never visible
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_dst_mac   <= '0;
         r_src_mac   <= '0;
         r_ethertype <= '0;
         r_is_bcast  <= 1'b0;
         r_match     <= 1'b0;
         r_is_ip     <= 1'b0;
      end else if (r_state == S_CHECK) begin
         r_dst_mac   <= w_dst;
         r_src_mac   <= w_src;
         r_ethertype <= w_type;
         r_is_bcast  <= w_bcast;
         r_match     <= w_match;
         r_is_ip     <= w_ip;
      end
   end
endmodule

// File: tb/tb_eth_hdr_parse.sv
// tb_eth_hdr_parse: randomized and directed checks of eth_hdr_parse against a byte-level header model
module tb_eth_hdr_parse;
   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_start;
   logic [47:0] mac;
   logic [7:0]  rd_data;
   logic [3:0]  o_rd_addr, b_rd_addr;
   logic        o_rd_en, b_rd_en;
   logic [47:0] o_dst_mac, o_src_mac, b_dst_mac, b_src_mac;
   logic [15:0] o_ethertype, b_ethertype;
   logic        o_is_bcast, o_match, o_is_ip, o_busy, o_done;
   logic        b_is_bcast, b_match, b_is_ip, b_busy, b_done;
   logic [7:0]  mem [14];
   logic [114:0] exp_res, prev_res;
   logic        exp_match_nb;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 i_clk = ~i_clk;

   eth_hdr_parse #(.ACCEPT_BCAST(1'b1)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_mac0(mac[47:40]), .i_mac1(mac[39:32]), .i_mac2(mac[31:24]),
      .i_mac3(mac[23:16]), .i_mac4(mac[15:8]), .i_mac5(mac[7:0]),
      .i_start(i_start), .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en), .i_rd_data(rd_data),
      .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_ethertype(o_ethertype),
      .o_is_bcast(o_is_bcast), .o_match(o_match), .o_is_ip(o_is_ip),
      .o_busy(o_busy), .o_done(o_done));

   eth_hdr_parse #(.ACCEPT_BCAST(1'b0)) dut_nb (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_mac0(mac[47:40]), .i_mac1(mac[39:32]), .i_mac2(mac[31:24]),
      .i_mac3(mac[23:16]), .i_mac4(mac[15:8]), .i_mac5(mac[7:0]),
      .i_start(i_start), .o_rd_addr(b_rd_addr), .o_rd_en(b_rd_en), .i_rd_data(rd_data),
      .o_dst_mac(b_dst_mac), .o_src_mac(b_src_mac), .o_ethertype(b_ethertype),
      .o_is_bcast(b_is_bcast), .o_match(b_match), .o_is_ip(b_is_ip),
      .o_busy(b_busy), .o_done(b_done));

   // Header buffer: synchronous RAM with one cycle of read latency
   always @(posedge i_clk) if (o_rd_en) rd_data <= mem[o_rd_addr];

   function automatic logic [114:0] res_now();
      return {o_dst_mac, o_src_mac, o_ethertype, o_is_bcast, o_match, o_is_ip};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Load the buffer with 14 header bytes and derive the expected results from them
   task automatic load(input logic [111:0] h);
      logic [47:0] d;
      logic [15:0] t;
      for (int k = 0; k < 14; k++) mem[k] = h[111 - 8*k -: 8];
      d = {mem[0], mem[1], mem[2], mem[3], mem[4], mem[5]};
      t = {mem[12], mem[13]};
      exp_match_nb = (d == mac);
      exp_res = {d, mem[6], mem[7], mem[8], mem[9], mem[10], mem[11], t,
                 d == 48'hFFFF_FFFF_FFFF, (d == mac) || (d == 48'hFFFF_FFFF_FFFF), t == 16'h0800};
   endtask

   // One full parse; n counts cycles after the trigger edge
   task automatic do_parse(input string nm);
      i_start = 1'b0;
      tick();
      i_start = 1'b1;
      tick();
      for (int n = 1; n <= 18; n++) begin
         chk({nm, ".rd_en"}, o_rd_en, n <= 14);
         chk({nm, ".busy"}, o_busy, n <= 17);
         chk({nm, ".done"}, o_done, n == 17);
         if (n <= 14) chk({nm, ".addr"}, o_rd_addr, n - 1);
         else chk({nm, ".addr_hold"}, o_rd_addr, 13);
         if (n < 17) chk({nm, ".hold_prev"}, res_now(), prev_res);
         else chk({nm, ".result"}, res_now(), exp_res);
         if (n == 17) chk({nm, ".match_nobcast"}, b_match, exp_match_nb);
         tick();
      end
      i_start = 1'b0;
      prev_res = exp_res;
   endtask

   initial begin
      int n_done, n_rd;
      logic [47:0] d;
      logic [15:0] t;
      i_rst = 1'b1;
      i_start = 1'b0;
      mac = 48'h0;
      for (int k = 0; k < 14; k++) mem[k] = 8'h00;
      prev_res = '0;
      tick();
      tick();
      chk("rst.during", {o_rd_addr, o_rd_en, o_busy, o_done, res_now()}, 0);
      i_rst = 1'b0;
      tick();
      chk("rst.after", {o_rd_addr, o_rd_en, o_busy, o_done, res_now()}, 0);

      mac = 48'h02_11_22_33_44_55;
      load(112'h021122334455_00AABBCCDDEE_0800);
      do_parse("uni_ip");
      load(112'hFFFFFFFFFFFF_00AABBCCDDEE_0806);
      do_parse("bcast_arp");
      load(112'h021122334456_0A0B0C0D0E0F_86DD);
      do_parse("foreign");

      for (int i = 0; i < 10; i++) begin
         mac = {$urandom, $urandom};
         case ($urandom_range(0, 2))
            0: d = mac;
            1: d = 48'hFFFF_FFFF_FFFF;
            default: d = {$urandom, $urandom};
         endcase
         t = ($urandom_range(0, 1) == 0) ? 16'h0800 : 16'($urandom);
         load({d, $urandom, 16'($urandom), t});
         do_parse($sformatf("rand%0d", i));
      end

      mac = 48'h02_11_22_33_44_55;
      load(112'h021122334455_123456789ABC_0800);
      i_start = 1'b0;
      tick();
      i_start = 1'b1;
      tick();
      n_done = 0;
      n_rd = 0;
      for (int n = 1; n <= 44; n++) begin
         n_done += int'(o_done);
         n_rd += int'(o_rd_en);
         chk("hold.done", o_done, n == 17);
         if (n == 17) chk("hold.result", res_now(), exp_res);
         if (n == 4) i_start = 1'b0;
         if (n == 5) i_start = 1'b1;
         if (n == 40) i_start = 1'b0;
         tick();
      end
      chk("hold.n_done", n_done, 1);
      chk("hold.n_rd", n_rd, 14);
      prev_res = exp_res;

      load(112'hFFFFFFFFFFFF_0000DEADBEEF_0800);
      i_start = 1'b0;
      tick();
      i_start = 1'b1;
      tick();
      for (int n = 1; n < 8; n++) tick();
      i_rst = 1'b1;
      #1;
      chk("midrst.imm", {o_rd_addr, o_rd_en, o_busy, o_done, res_now()}, 0);
      tick();
      chk("midrst.c1", {o_rd_addr, o_rd_en, o_busy, o_done, res_now()}, 0);
      tick();
      i_rst = 1'b0;
      i_start = 1'b0;
      n_done = 0;
      for (int n = 0; n < 20; n++) begin
         n_done += int'(o_done | o_busy);
         tick();
      end
      chk("midrst.quiet", n_done, 0);
      chk("midrst.after", {o_rd_addr, o_rd_en, o_busy, o_done, res_now()}, 0);
      prev_res = '0;
      do_parse("post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
